gate_truth_sequencer: RTL and testbench

//  Self-checking controller for one 2-input combinational gate (e.g. the NAND-built AND).
//  On start it drives the four input vectors {a,b}=00,01,10,11 in order and waits a

---
 rtl/gate_truth_sequencer_if.sv | 37 +++
 rtl/gate_truth_sequencer.sv | 147 ++++++++++++++
 tb/tb_gate_truth_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_sequencer_if.sv
// rtl/gate_truth_sequencer_if.sv - signal bundle between config master, sequencer and gate under check
//
// Purpose: groups the scan control, gate drive/observe and result signals of
//          gate_truth_sequencer so they travel as a single port.
// Signals:
//   start    master -> seq   begin a scan (honoured only while idle)
//   abort    master -> seq   cancel a running scan
//   dut_out  gate   -> seq   output of the gate under check
//   drv_a    seq -> gate     gate input a
//   drv_b    seq -> gate     gate input b
//   busy     seq -> master   scan in progress
//   done     seq -> master   one-cycle scan-complete pulse
//   pass     seq -> master   last completed scan had no mismatches
//   fail_vec seq -> master   per-vector mismatch flags, bit index = {a,b}
// Modports: slave = sequencer view, master = test/config + gate view.

interface gate_truth_sequencer_if;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;

  modport slave (
    input  start, abort, dut_out,
    output drv_a, drv_b, busy, done, pass, fail_vec
  );

  modport master (
    output start, abort, dut_out,
    input  drv_a, drv_b, busy, done, pass, fail_vec
  );
endinterface

// File: rtl/gate_truth_sequencer.sv
// rtl/gate_truth_sequencer.sv - exhaustive truth-table checker for one 2-input gate
//
// Purpose: on start, drives {a,b} = 00,01,10,11, holds each for SETTLE_CYCLES
//          cycles, samples the gate output on the last cycle of each vector and
//          compares it with EXPECT[{a,b}]. Reports per-vector mismatches, an
//          overall pass flag and a one-cycle done pulse. abort cancels a scan
//          without a done pulse and clears the results.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of gate_truth_sequencer_if (start, abort, dut_out in;
//            drv_a, drv_b, busy, done, pass, fail_vec out, all registered)
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   CNT_W          settle counter width; SETTLE_CYCLES < 2**CNT_W
//   EXPECT         expected gate output, bit index = {a,b}

module gate_truth_sequencer #(
  parameter int           SETTLE_CYCLES = 2,
  parameter int           CNT_W         = 4,
  parameter logic [3:0]   EXPECT        = 4'b1000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  gate_truth_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       vec_idx, vec_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             drv_a, drv_a_n;
  logic             drv_b, drv_b_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             pass, pass_n;
  logic [3:0]       fail_vec, fail_vec_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      vec_idx  <= 2'd0;
      cnt      <= '0;
      drv_a    <= 1'b0;
      drv_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 4'd0;
    end else begin
      state    <= state_n;
      vec_idx  <= vec_idx_n;
      cnt      <= cnt_n;
      drv_a    <= drv_a_n;
      drv_b    <= drv_b_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      fail_vec <= fail_vec_n;
    end
  end

  always_comb begin
    state_n    = state;
    vec_idx_n  = vec_idx;
    cnt_n      = cnt;
    drv_a_n    = drv_a;
    drv_b_n    = drv_b;
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    fail_vec_n = fail_vec;

    case (state)
      IDLE: begin
        // abort has no meaning here; only start is looked at.
        if (bus.start) begin
          state_n    = RUN;
          vec_idx_n  = 2'd0;
          cnt_n      = CNT_RELOAD;
          drv_a_n    = 1'b0;
          drv_b_n    = 1'b0;
          busy_n     = 1'b1;
          pass_n     = 1'b0;
          fail_vec_n = 4'd0;
        end
      end

      RUN: begin
        if (bus.abort) begin
          // Abort wins over a sample due on the same edge.
          state_n    = IDLE;
          vec_idx_n  = 2'd0;
          cnt_n      = '0;
          drv_a_n    = 1'b0;
          drv_b_n    = 1'b0;
          busy_n     = 1'b0;
          pass_n     = 1'b0;
          fail_vec_n = 4'd0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          // Last settle cycle of this vector: dut_out reflects drv_* now.
          fail_vec_n[vec_idx] = (bus.dut_out != EXPECT[vec_idx]);
          if (vec_idx == 2'd3) begin
            state_n   = DONE;
            vec_idx_n = 2'd0;
            drv_a_n   = 1'b0;
            drv_b_n   = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            // Verdict must include the bit written on this very edge.
            pass_n    = (fail_vec_n == 4'd0);
          end else begin
            vec_idx_n          = vec_idx + 2'd1;
            {drv_a_n, drv_b_n} = vec_idx + 2'd1;
            cnt_n              = CNT_RELOAD;
          end
        end
      end

      DONE: begin
        // start here is dropped, not queued.
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.drv_a    = drv_a;
  assign bus.drv_b    = drv_b;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.fail_vec = fail_vec;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb/tb_gate_truth_sequencer.sv - directed self-checking bench for gate_truth_sequencer

module tb_gate_truth_sequencer;

  logic clock;
  logic reset_n;
  logic or_mode;

  int n_cmp;
  int n_err;

  gate_truth_sequencer_if bus_a ();
  gate_truth_sequencer_if bus_b ();

  // Gate models: bus_a switches between AND and OR, bus_b is always AND.
  assign bus_a.dut_out = or_mode ? (bus_a.drv_a | bus_a.drv_b) : (bus_a.drv_a & bus_a.drv_b);
  assign bus_b.dut_out = bus_b.drv_a & bus_b.drv_b;

  gate_truth_sequencer #(
    .SETTLE_CYCLES (2),
    .CNT_W         (4),
    .EXPECT        (4'b1000)
  ) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  gate_truth_sequencer #(
    .SETTLE_CYCLES (1),
    .CNT_W         (4),
    .EXPECT        (4'b1000)
  ) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, " busy"},     32'(bus_a.busy), 0);
    check({tag, " done"},     32'(bus_a.done), 0);
    check({tag, " drv"},      32'({bus_a.drv_a, bus_a.drv_b}), 0);
  endtask

  // One full scan on bus_a, SETTLE=2. Optional start re-pulse at busy cycle restart_at.
  task automatic run_scan(input string tag, input logic [3:0] exp_fail,
                          input logic exp_pass, input int restart_at);
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_a.start = (i == restart_at);
      check({tag, " busy"}, 32'(bus_a.busy), 1);
      check({tag, " drv"},  32'({bus_a.drv_a, bus_a.drv_b}), 32'(i / 2));
      check({tag, " done"}, 32'(bus_a.done), 0);
      if (i == 0) begin
        check({tag, " clr fail_vec"}, 32'(bus_a.fail_vec), 0);
        check({tag, " clr pass"},     32'(bus_a.pass), 0);
      end
      @(negedge clock);
    end
    bus_a.start = 1'b0;
    check({tag, " done pulse"}, 32'(bus_a.done), 1);
    check({tag, " busy end"},   32'(bus_a.busy), 0);
    check({tag, " drv end"},    32'({bus_a.drv_a, bus_a.drv_b}), 0);
    check({tag, " fail_vec"},   32'(bus_a.fail_vec), 32'(exp_fail));
    check({tag, " pass"},       32'(bus_a.pass), 32'(exp_pass));
    @(negedge clock);
    check({tag, " done low"},   32'(bus_a.done), 0);
    check({tag, " idle busy"},  32'(bus_a.busy), 0);
    check({tag, " pass held"},  32'(bus_a.pass), 32'(exp_pass));
    check({tag, " fail held"},  32'(bus_a.fail_vec), 32'(exp_fail));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    or_mode = 1'b0;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check_idle_a("rst");
    check("rst pass",     32'(bus_a.pass), 0);
    check("rst fail_vec", 32'(bus_a.fail_vec), 0);
    check("rst b busy",   32'(bus_b.busy), 0);
    reset_n = 1'b1;
    @(negedge clock);
    bus_a.abort = 1'b1;
    @(negedge clock);
    bus_a.abort = 1'b0;
    check_idle_a("idle abort");

    // 1: AND gate passes
    run_scan("t1", 4'b0000, 1'b1, -1);

    // 2: OR gate mismatches on 01 and 10
    or_mode = 1'b1;
    run_scan("t2", 4'b0110, 1'b0, -1);

    // 3: start while busy ignored, then a normal rescan
    or_mode = 1'b0;
    run_scan("t3a", 4'b0000, 1'b1, 3);
    @(negedge clock);
    check("t3 no queued start", 32'(bus_a.busy), 0);
    run_scan("t3b", 4'b0000, 1'b1, -1);

    // 4: abort at vec_idx==2 on OR gate
    or_mode = 1'b1;
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    repeat (4) @(negedge clock);
    check("t4 drv at abort",  32'({bus_a.drv_a, bus_a.drv_b}), 2);
    check("t4 fail before",   32'(bus_a.fail_vec), 32'h2);
    bus_a.abort = 1'b1;
    @(negedge clock);
    bus_a.abort = 1'b0;
    check_idle_a("t4 after abort");
    check("t4 fail_vec",      32'(bus_a.fail_vec), 0);
    check("t4 pass",          32'(bus_a.pass), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t4 no done", 32'(bus_a.done), 0);
      check("t4 stays idle", 32'(bus_a.busy), 0);
    end

    // 5: asynchronous reset mid-scan (vec_idx==1)
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    repeat (2) @(negedge clock);
    check("t5 drv before rst", 32'({bus_a.drv_a, bus_a.drv_b}), 1);
    check("t5 busy before rst", 32'(bus_a.busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_a("t5 async rst");
    check("t5 rst fail_vec", 32'(bus_a.fail_vec), 0);
    check("t5 rst pass",     32'(bus_a.pass), 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle_a("t5 post rst");
    end

    // 6: SETTLE=1, start held -> back-to-back scans, period 6
    or_mode = 1'b0;
    bus_b.start = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        check("t6 busy", 32'(bus_b.busy), 32'(i < 4));
        check("t6 done", 32'(bus_b.done), 32'(i == 4));
        check("t6 drv",  32'({bus_b.drv_a, bus_b.drv_b}), (i < 4) ? 32'(i) : 0);
        if (i == 4) begin
          check("t6 pass",     32'(bus_b.pass), 1);
          check("t6 fail_vec", 32'(bus_b.fail_vec), 0);
        end
        @(negedge clock);
      end
    end
    bus_b.start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
